// File: rtl/gpr_pkg.sv
// gpr_pkg: shared register-file address and scoreboard types
package gpr_pkg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_GPRS = 32;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [NUM_GPRS-1:0] pending_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: pending-write bitmap, WAW issue stall and operand hazard lookup
module gpr_scoreboard import gpr_pkg::*; (
    input  logic clk,
    input  logic nreset,
    input  logic issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic issue_ready,
    input  logic clr_en,
    input  logic [REG_ADDR_WIDTH-1:0] clr_rd,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs0,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs1,
    output logic hazard_0,
    output logic hazard_1
);
    pending_t pending, set_mask, clr_mask;
    always_comb begin
        clr_mask = clr_en ? pending_t'(1) << clr_rd : '0;
        issue_ready = nreset & !((issue_rd != '0) & pending[issue_rd] & !clr_mask[issue_rd]);
        set_mask = (issue_valid & issue_ready & (issue_rd != '0)) ? pending_t'(1) << issue_rd : '0;
        hazard_0 = (query_rs0 != '0) & pending[query_rs0];
        hazard_1 = (query_rs1 != '0) & pending[query_rs1];
    end
    // set is applied after clear so a same-edge re-reservation survives
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) pending <= '0;
        else pending <= ((pending & ~clr_mask) | set_mask) & ~pending_t'(1);
endmodule

// File: rtl/gpr_writeback.sv
// gpr_writeback: mem-over-alu arbiter onto the registered GPR write port (GPR_WB_BYPASS_EN adds write-port forwarding)
module gpr_writeback import gpr_pkg::*; #(
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic nreset,
    input  logic issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic issue_ready,
    input  logic alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [REG_DATA_WIDTH-1:0] alu_data,
    output logic alu_ready,
    input  logic mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [REG_DATA_WIDTH-1:0] mem_data,
    output logic mem_ready,
    output logic [REG_ADDR_WIDTH-1:0] write_reg,
    output logic [REG_DATA_WIDTH-1:0] din,
    output logic din_enable,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs0,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs1,
    output logic hazard_0,
    output logic hazard_1
`ifdef GPR_WB_BYPASS_EN
    ,
    output logic bypass_hit_0,
    output logic bypass_hit_1,
    output logic [REG_DATA_WIDTH-1:0] bypass_data_0,
    output logic [REG_DATA_WIDTH-1:0] bypass_data_1
`endif
);
    logic acc, h0, h1;
    logic [REG_ADDR_WIDTH-1:0] acc_rd;
    logic [REG_DATA_WIDTH-1:0] acc_data;
    always_comb begin
        mem_ready = nreset;
        alu_ready = nreset & !mem_valid;
        acc_rd = mem_valid ? mem_rd : alu_rd;
        acc_data = mem_valid ? mem_data : alu_data;
        acc = (mem_valid | alu_valid) & (acc_rd != '0);
    end
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            write_reg <= '0;
            din <= '0;
            din_enable <= 1'b0;
        end else begin
            din_enable <= acc;
            if (acc) begin
                write_reg <= acc_rd;
                din <= acc_data;
            end
        end
    gpr_scoreboard u_sb (
        .clk(clk),
        .nreset(nreset),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .clr_en(din_enable),
        .clr_rd(write_reg),
        .query_rs0(query_rs0),
        .query_rs1(query_rs1),
        .hazard_0(h0),
        .hazard_1(h1)
    );
`ifdef GPR_WB_BYPASS_EN
    always_comb begin
        bypass_hit_0 = din_enable & (write_reg != '0) & (query_rs0 == write_reg);
        bypass_hit_1 = din_enable & (write_reg != '0) & (query_rs1 == write_reg);
        bypass_data_0 = bypass_hit_0 ? din : '0;
        bypass_data_1 = bypass_hit_1 ? din : '0;
        hazard_0 = h0 & !bypass_hit_0;
        hazard_1 = h1 & !bypass_hit_1;
    end
`else
    always_comb begin
        hazard_0 = h0;
        hazard_1 = h1;
    end
`endif
endmodule

// File: tb/tb_gpr_writeback.sv
// tb_gpr_writeback: directed checks of arbitration, scoreboard, WAW stall, x0 and reset
module tb_gpr_writeback;
    logic clk = 1'b0, nreset = 1'b0;
    logic issue_valid = 1'b0, issue_ready;
    logic [4:0] issue_rd = '0;
    logic alu_valid = 1'b0, alu_ready, mem_valid = 1'b0, mem_ready;
    logic [4:0] alu_rd = '0, mem_rd = '0, write_reg, query_rs0 = '0, query_rs1 = '0;
    logic [31:0] alu_data = '0, mem_data = '0, din;
    logic din_enable, hazard_0, hazard_1;
`ifdef GPR_WB_BYPASS_EN
    localparam logic BP = 1'b1;
    logic bypass_hit_0, bypass_hit_1;
    logic [31:0] bypass_data_0, bypass_data_1;
`else
    localparam logic BP = 1'b0;
`endif
    int total = 0, bad = 0;

    gpr_writeback dut (
        .clk(clk), .nreset(nreset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .write_reg(write_reg), .din(din), .din_enable(din_enable),
        .query_rs0(query_rs0), .query_rs1(query_rs1),
        .hazard_0(hazard_0), .hazard_1(hazard_1)
`ifdef GPR_WB_BYPASS_EN
        , .bypass_hit_0(bypass_hit_0), .bypass_hit_1(bypass_hit_1),
        .bypass_data_0(bypass_data_0), .bypass_data_1(bypass_data_1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        chk("rst_en", din_enable, 0);
        chk("rst_wr", write_reg, 0);
        chk("rst_din", din, 0);
        chk("rst_issue_rdy", issue_ready, 0);
        chk("rst_alu_rdy", alu_ready, 0);
        chk("rst_mem_rdy", mem_ready, 0);
        @(negedge clk);
        nreset = 1'b1; query_rs0 = 5'd3;
        #1;
        chk("issue_rdy", issue_ready, 1);
        chk("mem_rdy", mem_ready, 1);
        chk("alu_rdy", alu_ready, 1);
        chk("hz0_pre", hazard_0, 0);
        @(negedge clk);
        issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        #1;
        chk("hz0_set", hazard_0, 1);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("x3_en", din_enable, 1);
        chk("x3_wr", write_reg, 3);
        chk("x3_din", din, 32'hDEADBEEF);
        chk("hz0_during", hazard_0, {31'b0, !BP});
        @(negedge clk);
        #1;
        chk("hz0_after", hazard_0, 0);
        chk("idle_en", din_enable, 0);
        chk("hold_wr", write_reg, 3);
        chk("hold_din", din, 32'hDEADBEEF);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        #1;
        chk("prio_alu_rdy", alu_ready, 0);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        chk("prio_wr_mem", write_reg, 7);
        chk("prio_din_mem", din, 32'h77);
        chk("alu_rdy_again", alu_ready, 1);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("prio_wr_alu", write_reg, 5);
        chk("prio_din_alu", din, 32'h55);
        chk("prio_en_alu", din_enable, 1);
        issue_valid = 1'b1; issue_rd = 5'd9; query_rs1 = 5'd9;
        #1;
        chk("waw_first", issue_ready, 1);
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        #1;
        chk("waw_stall", issue_ready, 0);
        chk("hz1_x9", hazard_1, 1);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("waw_release", issue_ready, 1);
        chk("waw_en", din_enable, 1);
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        chk("waw_set_wins", hazard_1, 1);
        chk("waw_idle_en", din_enable, 0);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h199;
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("hz1_during", hazard_1, {31'b0, !BP});
        @(negedge clk);
        #1;
        chk("hz1_cleared", hazard_1, 0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        issue_valid = 1'b1; issue_rd = 5'd0; query_rs0 = 5'd0;
        #1;
        chk("x0_alu_rdy", alu_ready, 1);
        chk("x0_issue_rdy", issue_ready, 1);
        chk("x0_hz0", hazard_0, 0);
        @(negedge clk);
        alu_valid = 1'b0; issue_valid = 1'b0;
        #1;
        chk("x0_en", din_enable, 0);
        chk("x0_wr_hold", write_reg, 9);
        chk("x0_din_hold", din, 32'h199);
        chk("x0_hz0_after", hazard_0, 0);
        chk("x0_hz1_after", hazard_1, 0);
        issue_valid = 1'b1; issue_rd = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hCAFE; query_rs1 = 5'd4;
        @(negedge clk);
        issue_valid = 1'b0; alu_valid = 1'b0;
        #1;
        chk("x4_en", din_enable, 1);
        chk("x4_wr", write_reg, 4);
        chk("x4_hz1", hazard_1, {31'b0, !BP});
`ifdef GPR_WB_BYPASS_EN
        chk("bp_hit1", bypass_hit_1, 1);
        chk("bp_data1", bypass_data_1, 32'hCAFE);
        chk("bp_hit0", bypass_hit_0, 0);
        chk("bp_data0", bypass_data_0, 0);
`endif
        @(negedge clk);
        #1;
        chk("x4_hz1_after", hazard_1, 0);
`ifdef GPR_WB_BYPASS_EN
        chk("bp_hit1_after", bypass_hit_1, 0);
`endif
        issue_valid = 1'b1; issue_rd = 5'd10; query_rs0 = 5'd10;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hBB;
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        chk("mid_en", din_enable, 1);
        chk("mid_hz0", hazard_0, 1);
        chk("mid_issue_stall", issue_ready, 0);
        #1 nreset = 1'b0;
        #1;
        chk("mid_rst_en", din_enable, 0);
        chk("mid_rst_wr", write_reg, 0);
        chk("mid_rst_din", din, 0);
        chk("mid_rst_hz0", hazard_0, 0);
        chk("mid_rst_issue", issue_ready, 0);
        chk("mid_rst_mem", mem_ready, 0);
        @(negedge clk);
        nreset = 1'b1;
        #1;
        chk("post_rst_issue", issue_ready, 1);
        chk("post_rst_hz0", hazard_0, 0);
        issue_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpr_writeback.md
# gpr_writeback

Write-side front end for the general-purpose register file. Arbitrates results from the ALU and the load unit onto the register file's single write port, which has one cycle of registered latency. Keeps a 32-entry pending-write scoreboard, set by the issue stage and cleared on writeback. Answers hazard queries for the two source operands of the instruction being decoded.

## Interface
Parameters:
- REG_DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  issue stage requests to reserve issue_rd.
- issue_rd  in  5  destination register being issued.
- issue_ready  out  1  reservation accepted this cycle.
- alu_valid  in  1  ALU result available.
- alu_rd  in  5  ALU destination.
- alu_data  in  REG_DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU result consumed this cycle.
- mem_valid  in  1  load result available.
- mem_rd  in  5  load destination.
- mem_data  in  REG_DATA_WIDTH  load result.
- mem_ready  out  1  load result consumed this cycle.
- write_reg  out  5  register file write address (registered).
- din  out  REG_DATA_WIDTH  register file write data (registered).
- din_enable  out  1  register file write strobe (registered).
- query_rs0, query_rs1  in  5 each  operand registers to check.
- hazard_0, hazard_1  out  1 each  operand not yet readable.
- bypass_hit_0, bypass_hit_1  out  1 each  forwarded value valid (only with GPR_WB_BYPASS_EN).
- bypass_data_0, bypass_data_1  out  REG_DATA_WIDTH each  forwarded value (only with GPR_WB_BYPASS_EN).

## Operation
- Reset (nreset low, asynchronous):
  - write_reg=0, din=0, din_enable=0, pending=32'h0.
  - issue_ready, alu_ready and mem_ready all forced 0.
  - hazard and bypass outputs are 0.
- Arbitration: one result is accepted per cycle, with fixed priority mem over alu.
  - mem_ready = 1 when out of reset.
  - alu_ready = !mem_valid.
- Accepted result with rd≠0: write_reg, din and din_enable (=1) are loaded at the accepting edge.
- Accepted result with rd=0: the result is consumed, din_enable=0 next cycle, and the scoreboard is unchanged.
- No accept: din_enable=0 next cycle; write_reg and din hold their values.
- Scoreboard: pending[31:1] bitmap; bit 0 is hardwired 0.
  - Set: issue_valid & issue_ready & issue_rd≠0 sets pending[issue_rd] at the edge.
  - Clear: the cycle din_enable=1 clears pending[write_reg] at the end-of-cycle edge, i.e. the same edge at which the register file stores din.
  - Simultaneous set and clear of the same bit: set wins.
- WAW stall: issue_ready = !(issue_rd≠0 & pending[issue_rd] & !clear_this_cycle[issue_rd]).
  - Back-to-back writers to one register are impossible because a reservation can only be re-taken once the previous write lands.
  - issue_rd=0 is always ready.
- hazard_n = (query_rsn≠0) & pending[query_rsn], combinational. Without the macro it ignores any clear happening this cycle.

## Timing
- Acceptance at edge E → din_enable high during cycle E..E+1 → register file stores at E+1 → pending bit clears at E+1 → hazard drops the cycle after E+1.
- Register file read data reflects the write one cycle after E+1, so the minimum result-to-consumer distance without bypass is 2 cycles after acceptance.
- Ready outputs and hazards are combinational from current inputs and state; the write port outputs are purely registered.
- An unaccepted ALU result must hold its valid, rd and data stable until alu_ready is seen; mem has no back-pressure.
- Mid-operation reset: the in-flight write is dropped (din_enable→0) and all reservations are lost; the issue stage is reset alongside.

## Configuration
- GPR_WB_BYPASS_EN defined:
  - While din_enable=1 and query_rsn==write_reg≠0: bypass_hit_n=1, bypass_data_n=din, and hazard_n forced 0.
  - Otherwise bypass_hit_n=0 and bypass_data_n=0.
- GPR_WB_BYPASS_EN undefined: the bypass ports are absent and hazard follows the plain pending rule.

## Structure
- Shared package gpr_pkg:
  - REG_ADDR_WIDTH=5 and NUM_GPRS=32.
  - Typedef for a register address.
  - Typedef for the 32-bit pending mask.
- Sub-module gpr_scoreboard holds:
  - the pending bitmap and its set/clear logic;
  - issue_ready;
  - the hazard lookups.
- gpr_writeback holds the arbiter, the write port registers and the bypass logic.

## Test plan
- Reset: assert nreset=0 mid-write (din_enable=1) → din_enable=0, write_reg=0, pending=0 immediately; issue_ready=0 until release.
- Priority: alu_valid and mem_valid both 1 with rd 5/7 → mem accepted (write_reg=7 next cycle), alu_ready=0; next cycle write_reg=5.
- Scoreboard: issue rd=3 → hazard_0=1 for query_rs0=3; ALU writes x3=32'hDEADBEEF → hazard_0 stays 1 during the din_enable cycle (no bypass) and is 0 the cycle after.
- WAW: issue rd=9 twice → second issue_ready=0 until the cycle x9's din_enable is high; then issue is accepted and pending[9] stays 1.
- rd=0: ALU result to x0 with data 32'h1234 → alu_ready=1, din_enable stays 0, pending unchanged, hazard_n=0 for query 0.
- Bypass (macro on): query_rs1=4 during din_enable with write_reg=4, din=32'hCAFE → bypass_hit_1=1, bypass_data_1=32'hCAFE, hazard_1=0.
